multdiv_seq: RTL and testbench
==============================

Name: multdiv_seq

Overview:
- Multi-cycle signed 32-bit multiply/divide unit for the processor's execute stage.
- Computes through one shared `add32` adder and `neg32` negators instead of a combinational array.
- Sequences 32 iteration cycles plus one sign-fix cycle, then pulses a ready strobe.
- The pipeline stalls on busy and consumes `data_result` when ready pulses.

Parameters:
WIDTH, 32, operand/result width; only 32 supported (matches `add32`/`neg32`).
ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
clock  input  1  rising-edge clock.
resetn  input  1  asynchronous active-low reset.
ctrl_MULT  input  1  one-cycle start pulse, signed multiply.
ctrl_DIV  input  1  one-cycle start pulse, signed divide.
data_operandA  input  32  multiplicand/dividend; sampled only on a start edge.
data_operandB  input  32  multiplier/divisor; sampled only on a start edge.
data_result  output  32  result; held until the next start or reset.
data_exception  output  1  overflow or divide-by-zero flag, valid with the result.
data_resultRDY  output  1  one-cycle done strobe.
busy  output  1  high from the cycle after a start through the cycle data_resultRDY is high.

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; all internal registers cleared.
  - Reset mid-operation aborts it; no ready pulse follows.
- States: IDLE -> MUL or DIV (ITER cycles) -> FIX (1 cycle) -> DONE (1 cycle, RDY=1) -> IDLE.
- Start:
  - Edge E0 samples ctrl_MULT=1 or ctrl_DIV=1.
  - On E0, capture |A|, |B| via `neg32`, capture result sign (A[31]^B[31]), clear the counter.
  - Both ctrl asserted on the same edge: MULT wins.
- Restart: a start in any non-IDLE state aborts the current op and restarts with the new operands and op; the aborted op never pulses RDY.
- Latency: iterations on edges E1..E32, FIX on E33, data_resultRDY high between E33 and E34, back to 0 after E34.
- MUL iteration (unsigned shift-add on magnitudes):
  - 64-bit product register {P_hi, P_lo}.
  - If P_lo[0]=1, P_hi = `add32`(P_hi, |A|), keeping the 33rd carry bit; then shift the 65-bit value right by 1.
- DIV iteration (restoring):
  - Remainder R shifts left, bringing in the dividend MSB.
  - Trial = R + `neg32`(|B|) via `add32`. Trial non-negative: R=trial, quotient bit=1. Otherwise R unchanged, bit=0.
- FIX:
  - Result = magnitude, or `neg32`(magnitude) if the sign bit is 1 and the magnitude is nonzero.
  - Division truncates toward zero; remainder is discarded.
- Exceptions:
  - MUL: exception=1 when the signed product does not fit in 32 bits, i.e. magnitude > 0x7FFFFFFF, except magnitude == 0x80000000 with a negative sign. data_result = low 32 bits of the true product.
  - DIV by zero: exception=1, data_result=0, still full latency.
  - DIV of 0x80000000 by -1: exception=1, data_result=0x80000000.
- Operand inputs and ctrl are ignored outside start edges; operands may change freely during busy.
- data_result and data_exception update only at E33 of a completed op.

Decomposition:
- Shared package (multdiv_pkg):
  - state encoding constants IDLE/MUL/DIV/FIX/DONE;
  - ITER;
  - INT_MIN = 32'h80000000.
- Existing `add32` and `neg32` are instanced directly; no new arithmetic sub-module.
- One natural sub-module: `iter_counter` (6-bit, clear/enable, terminal-count output at ITER-1), also reusable by future multi-cycle units.

Test Plan:
- MULT A=7, B=-3 (0xFFFFFFFD) -> after E33: result=0xFFFFFFEB, exception=0; RDY high exactly one cycle; busy high E0..E34.
- MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. MULT A=0x80000000, B=1 -> result=0x80000000, exception=0.
- DIV A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. DIV A=100, B=7 -> result=14.
- DIV A=5, B=0 -> result=0, exception=1 at E33. DIV A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- Restart: MULT(3,4) at E0, DIV(20,5) at E10 -> single RDY at E10+33, result=4; no RDY near E33.
- Reset: MULT(3,4) started, resetn low at E15 for 2 cycles -> outputs 0 immediately (asynchronous), busy=0, no RDY for 40 cycles; a simultaneous ctrl_MULT+ctrl_DIV afterwards performs MULT.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the sequential multiply/divide unit.
package multdiv_pkg;
    localparam int          ITER    = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;
endpackage

// File: rtl/add32.sv
// 32-bit unsigned adder with carry out.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/multdiv_iter_counter.sv
// 6-bit iteration counter with clear/enable and terminal count at ITER-1.
module iter_counter #(
    parameter int ITER = 32
) (
    input  logic clock,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [5:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)  cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + 6'd1;
    end

    assign tc = (cnt == 6'(ITER - 1));
endmodule

// File: rtl/neg32.sv
// 32-bit two's complement negator.
module neg32 (
    input  logic [31:0] a,
    output logic [31:0] y
);
    assign y = ~a + 32'd1;
endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply/divide: shift-add multiply, restoring divide,
// magnitudes computed up front and the sign applied in a final fix cycle.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    import multdiv_pkg::*;

    state_t state, state_n;

    logic [WIDTH-1:0] amag, bmag, phi, plo;
    logic             sign, is_div;
    logic             start, tc;
    logic [WIDTH-1:0] nega, negb, negbm, neglo;
    logic [WIDTH-1:0] rshift, add_a, add_b, sum;
    logic             cout;
    logic [WIDTH-1:0] fix_res;
    logic             fix_exc, mul_ovf, div_zero, div_ovf;

    assign start = ctrl_MULT | ctrl_DIV;

    neg32 u_nega  (.a(data_operandA), .y(nega));
    neg32 u_negb  (.a(data_operandB), .y(negb));
    neg32 u_negbm (.a(bmag),          .y(negbm));
    neg32 u_neglo (.a(plo),           .y(neglo));

    // Divide reuses phi as the remainder and plo as dividend/quotient shifter.
    assign rshift = {phi[WIDTH-2:0], plo[WIDTH-1]};
    assign add_a  = (state == DIV) ? rshift : phi;
    assign add_b  = (state == DIV) ? negbm  : amag;

    add32 u_add (.a(add_a), .b(add_b), .sum(sum), .cout(cout));

    iter_counter #(.ITER(ITER)) u_cnt (
        .clock (clock),
        .resetn(resetn),
        .clr   (start),
        .en    ((state == MUL) || (state == DIV)),
        .tc    (tc)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (start) begin
            state_n = ctrl_MULT ? MUL : DIV;
        end else begin
            case (state)
                IDLE:    state_n = IDLE;
                MUL,
                DIV:     if (tc) state_n = FIX;
                FIX:     state_n = DONE;
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Product magnitude exceeds signed range unless it is exactly INT_MIN with a negative sign.
    assign mul_ovf  = ((phi != '0) || plo[WIDTH-1]) &&
                      !(sign && (phi == '0) && (plo == INT_MIN));
    assign div_zero = (bmag == '0);
    assign div_ovf  = !sign && (plo == INT_MIN);

    always_comb begin
        fix_res = sign ? neglo : plo;
        fix_exc = mul_ovf;
        if (is_div) begin
            fix_exc = div_zero | div_ovf;
            if (div_zero) fix_res = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            amag           <= '0;
            bmag           <= '0;
            phi            <= '0;
            plo            <= '0;
            sign           <= 1'b0;
            is_div         <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            amag   <= data_operandA[WIDTH-1] ? nega : data_operandA;
            bmag   <= data_operandB[WIDTH-1] ? negb : data_operandB;
            sign   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            is_div <= !ctrl_MULT;
            phi    <= '0;
            if (ctrl_MULT) plo <= data_operandB[WIDTH-1] ? negb : data_operandB;
            else           plo <= data_operandA[WIDTH-1] ? nega : data_operandA;
        end else begin
            case (state)
                MUL: begin
                    if (plo[0]) {phi, plo} <= {cout, sum, plo[WIDTH-1:1]};
                    else        {phi, plo} <= {1'b0, phi, plo[WIDTH-1:1]};
                end
                DIV: begin
                    phi <= cout ? sum : rshift;
                    plo <= {plo[WIDTH-2:0], cout};
                end
                FIX: begin
                    data_result    <= fix_res;
                    data_exception <= fix_exc;
                end
                default: ;
            endcase
        end
    end

    assign busy           = (state != IDLE);
    assign data_resultRDY = (state == DONE);
endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq: directed ops push expectations, a monitor checks each ready pulse.
module tb_multdiv_seq;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    multdiv_seq dut (
        .clock         (clock),
        .resetn        (resetn),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          rdy_cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (resetn && data_resultRDY === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("result",    data_result,           mon_e.res);
                chk("exception", {31'b0, data_exception}, {31'b0, mon_e.exc});
                chk("latency",   cyc,                   mon_e.rdy_cyc);
            end
        end
    end

    // Drives a one-cycle start; returns the index of the sampling edge E0.
    task automatic issue(input logic m, input logic d, input logic [31:0] a,
                         input logic [31:0] b, output int e0);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        e0            = cyc + 1;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic expect_op(input int e0, input logic [31:0] res, input logic exc);
        exp_t e;
        e.res     = res;
        e.exc     = exc;
        e.rdy_cyc = e0 + 33;
        sbq.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=pending expected=rdy cyc=%0d", cyc);
            sbq.delete();
        end
        @(negedge clock);
    endtask

    task automatic run(input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic exc);
        int e0;
        issue(m, d, a, b, e0);
        expect_op(e0, res, exc);
        wait_done();
    endtask

    initial begin
        int e0;
        #1;
        chk("rst_result", data_result, 32'h0);
        chk("rst_exc",    {31'b0, data_exception}, 32'h0);
        chk("rst_busy",   {31'b0, busy}, 32'h0);
        chk("rst_rdy",    {31'b0, data_resultRDY}, 32'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        // 7 * -3 with explicit busy/ready timing
        chk("busy_idle", {31'b0, busy}, 32'h0);
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, e0);
        expect_op(e0, 32'hFFFF_FFEB, 1'b0);
        chk("busy_e0", {31'b0, busy}, 32'h1);
        repeat (32) @(negedge clock);
        chk("busy_e32", {31'b0, busy}, 32'h1);
        chk("rdy_e32",  {31'b0, data_resultRDY}, 32'h0);
        @(negedge clock);
        chk("busy_e33", {31'b0, busy}, 32'h1);
        chk("rdy_e33",  {31'b0, data_resultRDY}, 32'h1);
        @(negedge clock);
        chk("busy_e34", {31'b0, busy}, 32'h0);
        chk("rdy_e34",  {31'b0, data_resultRDY}, 32'h0);
        chk("sb_empty", sbq.size(), 32'h0);

        run(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 1'b0);
        run(1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30,        1'b0);
        run(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        run(1'b0, 1'b1, 32'd100,       32'd7,         32'd14,        1'b0);
        run(1'b0, 1'b1, 32'd5,         32'd0,         32'h0000_0000, 1'b1);
        run(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // Restart: DIV at E10 aborts the MULT; only one ready, 33 edges after E10
        issue(1'b1, 1'b0, 32'd3, 32'd4, e0);
        repeat (8) @(negedge clock);
        issue(1'b0, 1'b1, 32'd20, 32'd5, e0);
        expect_op(e0, 32'd4, 1'b0);
        wait_done();
        chk("result_held", data_result, 32'd4);

        // Asynchronous reset mid-operation
        issue(1'b1, 1'b0, 32'd3, 32'd4, e0);
        repeat (14) @(negedge clock);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("arst_result", data_result, 32'h0);
        chk("arst_exc",    {31'b0, data_exception}, 32'h0);
        chk("arst_busy",   {31'b0, busy}, 32'h0);
        chk("arst_rdy",    {31'b0, data_resultRDY}, 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        repeat (40) @(negedge clock);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);

        // Both starts asserted: multiply takes priority
        run(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
